// File: rtl/ram_bank_be.sv
// ram_bank_be: byte-enabled synchronous RAM for the iCE40 LP8K, organised as a
// grid of 256x16 block RAMs (DATA_W/16 slices wide, 2**(ADDR_W-8) banks deep).
// Adds write-first forwarding, a read-valid flag and an optional clear sweep
// after reset during which the memory refuses requests.
//
// Ports:
//   CLK     single clock for every block RAM read and write port
//   RST     asynchronous reset, active-high (memory contents are not reset)
//   READY   high once the memory accepts requests
//   RE      read request; RADDR is the word address
//   WE      write request; WADDR/WDATA with byte enables WBE
//   RDATA   read data, zero whenever RVALID is low
//   RVALID  RDATA holds the result of the previous cycle's read
module ram_bank_be #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  READY,
    input  logic                  RE,
    input  logic [ADDR_W-1:0]     RADDR,
    input  logic                  WE,
    input  logic [ADDR_W-1:0]     WADDR,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WBE,
    output logic [DATA_W-1:0]     RDATA,
    output logic                  RVALID
);

    localparam int unsigned NSLICE = DATA_W / 16;
    localparam int unsigned NBYTE  = DATA_W / 8;
    localparam int unsigned NBANK  = 1 << (ADDR_W - 8);
    localparam int unsigned BANK_W = (ADDR_W > 8) ? ADDR_W - 8 : 1;

    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE_WAIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                ready_q, ready_d;
    logic                rvalid_q, rvalid_d;
    logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
    logic [NBYTE-1:0]    fwd_be_q, fwd_be_d;
    logic [DATA_W-1:0]   fwd_data_q, fwd_data_d;

    logic                re_eff;
    logic                user_we;
    logic                clearing;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NBYTE-1:0]    wr_be;
    logic [DATA_W-1:0]   wr_mask;
    logic [BANK_W-1:0]   wr_bank;
    logic [BANK_W-1:0]   rd_bank;
    logic [DATA_W-1:0]   bank_rdata [NBANK];
    logic [DATA_W-1:0]   raw_rdata;
    logic [DATA_W-1:0]   merged_rdata;

    // Requests only count once READY is up; READY is registered so this is
    // equivalent to being in RUN.
    assign re_eff   = RE & ready_q;
    assign user_we  = WE & ready_q;
    assign clearing = (state_q == ST_CLEAR);

    // The clear sweep borrows the write port: zero data, all bytes enabled.
    always_comb begin
        wr_en   = clearing | user_we;
        wr_addr = clearing ? clr_cnt_q : WADDR;
        wr_data = clearing ? '0 : WDATA;
        wr_be   = clearing ? '1 : WBE;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            wr_mask[i] = ~wr_be[i / 8];
        end
    end

    generate
        if (ADDR_W > 8) begin : g_bank_sel
            assign wr_bank = wr_addr[ADDR_W-1:8];
            assign rd_bank = RADDR[ADDR_W-1:8];
        end else begin : g_single_bank
            assign wr_bank = '0;
            assign rd_bank = '0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + CNT_ONE;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_IDLE_WAIT: state_d = ST_RUN;
            ST_RUN:       state_d = ST_RUN;
            default:      state_d = ST_RUN;
        endcase
        ready_d    = (state_d == ST_RUN);
        rvalid_d   = re_eff;
        rd_bank_d  = re_eff ? rd_bank : rd_bank_q;
        // The block RAM returns the pre-write word on a same-address
        // collision; remember which bytes the concurrent write replaces.
        fwd_be_d   = (re_eff && user_we && (RADDR == WADDR)) ? WBE : '0;
        fwd_data_d = WDATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            if (CLEAR_ON_RESET != 0) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_IDLE_WAIT;
            end
            clr_cnt_q  <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rd_bank_q  <= '0;
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ready_q    <= ready_d;
            rvalid_q   <= rvalid_d;
            rd_bank_q  <= rd_bank_d;
            fwd_be_q   <= fwd_be_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Every bank is read on each accepted request; the registered bank
    // select picks the result one cycle later.
    generate
        for (genvar b = 0; b < NBANK; b++) begin : g_bank
            logic             bank_we;
            logic [DATA_W-1:0] rdata;

            assign bank_we = wr_en && (wr_bank == BANK_W'(b));

            for (genvar s = 0; s < NSLICE; s++) begin : g_slice
                ram_bank_be_ram256x16 u_ram (
                    .RDATA (rdata[s*16 +: 16]),
                    .RCLK  (CLK),
                    .RCLKE (1'b1),
                    .RE    (re_eff),
                    .RADDR (RADDR[7:0]),
                    .WCLK  (CLK),
                    .WCLKE (1'b1),
                    .WE    (bank_we),
                    .WADDR (wr_addr[7:0]),
                    .MASK  (wr_mask[s*16 +: 16]),
                    .WDATA (wr_data[s*16 +: 16])
                );
            end

            assign bank_rdata[b] = rdata;
        end
    endgenerate

    always_comb begin
        raw_rdata = '0;
        for (int unsigned b = 0; b < NBANK; b++) begin
            if (rd_bank_q == BANK_W'(b)) begin
                raw_rdata = bank_rdata[b];
            end
        end
        for (int unsigned i = 0; i < NBYTE; i++) begin
            merged_rdata[8*i +: 8] = fwd_be_q[i] ? fwd_data_q[8*i +: 8]
                                                 : raw_rdata[8*i +: 8];
        end
        RDATA = rvalid_q ? merged_rdata : '0;
    end

    assign READY  = ready_q;
    assign RVALID = rvalid_q;

endmodule

// ram_bank_be_ram256x16: behavioural equivalent of the iCE40 SB_RAM256x16
// (same port names and semantics) that infers one 4 kbit block RAM.
//   RDATA  registered read data, read-before-write on address collision
//   RCLK/RCLKE/RE/RADDR  read port;  WCLK/WCLKE/WE/WADDR/WDATA  write port
//   MASK   active-low per-bit write mask
module ram_bank_be_ram256x16 (
    output logic [15:0] RDATA,
    input  logic        RCLK,
    input  logic        RCLKE,
    input  logic        RE,
    input  logic [7:0]  RADDR,
    input  logic        WCLK,
    input  logic        WCLKE,
    input  logic        WE,
    input  logic [7:0]  WADDR,
    input  logic [15:0] MASK,
    input  logic [15:0] WDATA
);

    logic [15:0] mem [256];
    logic [15:0] rdata_q;

    always_ff @(posedge WCLK) begin
        if (WCLKE && WE) begin
            mem[WADDR] <= (mem[WADDR] & MASK) | (WDATA & ~MASK);
        end
    end

    always_ff @(posedge RCLK) begin
        if (RCLKE && RE) begin
            rdata_q <= mem[RADDR];
        end
    end

    assign RDATA = rdata_q;

endmodule

// File: tb/tb_ram_bank_be.sv
// Directed bench for ram_bank_be (DATA_W=32, ADDR_W=9, clear sweep enabled).
// A word-level reference memory produces each expected read result when the
// request is driven; results are queued and checked when RVALID is due.
module tb_ram_bank_be;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ready;
    logic          re_i = 1'b0;
    logic [AW-1:0] raddr_i = '0;
    logic          we_i = 1'b0;
    logic [AW-1:0] waddr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [3:0]    wbe_i = '0;
    logic [DW-1:0] rdata;
    logic          rvalid;

    always #5 clk = ~clk;

    ram_bank_be #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .CLEAR_ON_RESET (1)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .READY  (ready),
        .RE     (re_i),
        .RADDR  (raddr_i),
        .WE     (we_i),
        .WADDR  (waddr_i),
        .WDATA  (wdata_i),
        .WBE    (wbe_i),
        .RDATA  (rdata),
        .RVALID (rvalid)
    );

    typedef struct {
        string         tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] mem_m [DEPTH];
    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    logic          rd_expect = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    // Drive one cycle of requests. When live, the reference memory takes the
    // write first so a same-address read sees the merged (write-first) word.
    task automatic drive(input logic re, input logic [AW-1:0] ra,
                         input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [3:0] be,
                         input logic live, input string tag);
        re_i    = re;
        raddr_i = ra;
        we_i    = we;
        waddr_i = wa;
        wdata_i = wd;
        wbe_i   = be;
        if (live && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_m[wa][8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (live && re) begin
            sb_q.push_back('{tag: tag, data: mem_m[ra]});
            rd_expect = 1'b1;
        end
    endtask

    // Advance one clock and check READY, RVALID and RDATA just after the edge.
    task automatic step(input logic exp_ready);
        logic exp_v;
        exp_t e;
        exp_v = rd_expect;
        @(posedge clk);
        #1;
        re_i      = 1'b0;
        we_i      = 1'b0;
        rd_expect = 1'b0;
        check("ready", DW'(ready), DW'(exp_ready));
        check("rvalid", DW'(rvalid), DW'(exp_v));
        if (exp_v) begin
            e = sb_q.pop_front();
            check(e.tag, rdata, e.data);
        end else begin
            check("rdata_idle", rdata, '0);
        end
    endtask

    initial begin
        model_zero();

        // Reset held, then a full 512-cycle sweep; a stray request at cycle 100
        // must be ignored.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 100) drive(1'b1, 9'h010, 1'b1, 9'h010, 32'hFFFFFFFF, 4'hF, 1'b0, "clr_req");
            step(i == DEPTH);
        end

        // Sweep leaves every bank boundary word at zero.
        drive(1'b1, 9'h000, 1'b0, '0, '0, '0, 1'b1, "rd_000");  step(1'b1);
        drive(1'b1, 9'h0FF, 1'b0, '0, '0, '0, 1'b1, "rd_0ff");  step(1'b1);
        drive(1'b1, 9'h100, 1'b0, '0, '0, '0, 1'b1, "rd_100");  step(1'b1);
        drive(1'b1, 9'h1FF, 1'b0, '0, '0, '0, 1'b1, "rd_1ff");  step(1'b1);
        drive(1'b1, 9'h010, 1'b0, '0, '0, '0, 1'b1, "rd_010");  step(1'b1);

        // Partial byte write over a full word.
        drive(1'b0, '0, 1'b1, 9'h105, 32'hDEADBEEF, 4'b1111, 1'b1, "");  step(1'b1);
        drive(1'b0, '0, 1'b1, 9'h105, 32'h000000AA, 4'b0001, 1'b1, "");  step(1'b1);
        drive(1'b1, 9'h105, 1'b0, '0, '0, '0, 1'b1, "rd_105");  step(1'b1);

        // Same-edge read and write: write-first forwarding on enabled bytes.
        drive(1'b0, '0, 1'b1, 9'h020, 32'hAABBCCDD, 4'b1111, 1'b1, "");  step(1'b1);
        drive(1'b1, 9'h020, 1'b1, 9'h020, 32'h11223344, 4'b1100, 1'b1, "fwd_020");  step(1'b1);
        drive(1'b1, 9'h020, 1'b0, '0, '0, '0, 1'b1, "rd_020");  step(1'b1);

        // WBE=0 is a no-op, also with a same-address read.
        drive(1'b1, 9'h030, 1'b1, 9'h030, 32'hFFFFFFFF, 4'b0000, 1'b1, "wbe0_fwd");  step(1'b1);
        drive(1'b1, 9'h030, 1'b0, '0, '0, '0, 1'b1, "wbe0_rd");  step(1'b1);

        // Bank crossing at full throughput, plus an unrelated concurrent write.
        drive(1'b0, '0, 1'b1, 9'h0FF, 32'hA5A5A5A5, 4'b1111, 1'b1, "");  step(1'b1);
        drive(1'b0, '0, 1'b1, 9'h100, 32'h5A5A5A5A, 4'b1111, 1'b1, "");  step(1'b1);
        drive(1'b1, 9'h0FF, 1'b1, 9'h1FF, 32'h12345678, 4'b1111, 1'b1, "xbank_wr");  step(1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i % 2 == 0) ? 9'h100 : 9'h0FF, 1'b0, '0, '0, '0, 1'b1, "xbank");
            step(1'b1);
        end
        drive(1'b1, 9'h1FF, 1'b0, '0, '0, '0, 1'b1, "rd_1ff_wr");  step(1'b1);

        // Reset in RUN, then again at sweep cycle 300: the sweep restarts.
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 300; i++) step(1'b0);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) step(i == DEPTH);
        model_zero();
        drive(1'b1, 9'h1FF, 1'b0, '0, '0, '0, 1'b1, "rst_1ff");  step(1'b1);
        drive(1'b1, 9'h105, 1'b0, '0, '0, '0, 1'b1, "rst_105");  step(1'b1);
        step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
